// File: rtl/ysyx_22050710_axi4full_sram_burst.sv
// ysyx_22050710_axi4full_sram_burst
// AXI4 slave around an on-chip word array. It supports FIXED, INCR and WRAP bursts,
// byte strobes and a programmable first-beat read latency. Unmapped or malformed
// beats return SLVERR. The read and write channels are independent state machines.
module ysyx_22050710_axi4full_sram_burst #(
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    ID_WIDTH     = 4,
    parameter int                    MEM_WORDS    = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(32'h8000_0000),
    parameter int                    READ_LATENCY = 1,
    parameter int                    STRB_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  i_aclk,
    input  logic                  i_arsetn,
    input  logic [ID_WIDTH-1:0]   i_awid,
    input  logic [ADDR_WIDTH-1:0] i_awaddr,
    input  logic [7:0]            i_awlen,
    input  logic [2:0]            i_awsize,
    input  logic [1:0]            i_awburst,
    input  logic                  i_awvalid,
    output logic                  o_awready,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [STRB_WIDTH-1:0] i_wstrb,
    input  logic                  i_wlast,
    input  logic                  i_wvalid,
    output logic                  o_wready,
    output logic [ID_WIDTH-1:0]   o_bid,
    output logic [1:0]            o_bresp,
    output logic                  o_bvalid,
    input  logic                  i_bready,
    input  logic [ID_WIDTH-1:0]   i_arid,
    input  logic [ADDR_WIDTH-1:0] i_araddr,
    input  logic [7:0]            i_arlen,
    input  logic [2:0]            i_arsize,
    input  logic [1:0]            i_arburst,
    input  logic                  i_arvalid,
    output logic                  o_arready,
    output logic [ID_WIDTH-1:0]   o_rid,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [1:0]            o_rresp,
    output logic                  o_rlast,
    output logic                  o_rvalid,
    input  logic                  i_rready
);

    localparam int                    LANE_BITS = $clog2(STRB_WIDTH);
    localparam int                    IDX_BITS  = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * STRB_WIDTH);
    // Number of R_WAIT cycles minus one; only meaningful when READ_LATENCY > 1.
    localparam logic [2:0]            LAT_LAST  = (READ_LATENCY > 1) ? 3'(READ_LATENCY - 2) : 3'd0;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2;
    localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;

    // Address of the beat after `addr`. Burst code 2'b11 is treated as INCR.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [7:0] len, input logic [2:0] size,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] win_mask;
        inc      = addr + (ADDR_WIDTH'(1) << size);
        win_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~win_mask) | (inc & win_mask);
            default:     next_addr = inc;
        endcase
    endfunction

    // A beat is rejected if it is outside the array, wider than the bus, or an illegal WRAP length.
    function automatic logic beat_err(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                      input logic [2:0] size, input logic [1:0] burst);
        logic bad_range;
        logic bad_wrap;
        bad_range = (addr < BASE_ADDR) || ((addr - BASE_ADDR) >= MEM_BYTES);
        bad_wrap  = (burst == BURST_WRAP) &&
                    !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        beat_err  = bad_range || (int'(size) > LANE_BITS) || bad_wrap;
    endfunction

    function automatic logic [IDX_BITS-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off      = (addr - BASE_ADDR) >> LANE_BITS;
        word_idx = IDX_BITS'(off);
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [1:0]            r_state_q, r_state_d;
    logic [2:0]            lat_q, lat_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [7:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [2:0]            rsize_q, rsize_d;
    logic [1:0]            rburst_q, rburst_d, rresp_q, rresp_d;
    logic                  rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [1:0]            w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   wid_q, wid_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [2:0]            wsize_q, wsize_d;
    logic [1:0]            wburst_q, wburst_d, bresp_q, bresp_d;
    logic                  werr_q, werr_d, bvalid_q, bvalid_d;

    logic                  ar_fire, r_fire, aw_fire, w_fire, b_fire;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [7:0]            ld_len;
    logic [2:0]            ld_size;
    logic [1:0]            ld_burst;
    logic                  ld_last, r_load, rd_err, wr_err, wr_last_beat, mem_we;

    assign o_arready = (r_state_q == R_IDLE);
    assign o_awready = (w_state_q == W_IDLE);
    assign o_wready  = (w_state_q == W_DATA);
    assign ar_fire   = i_arvalid & o_arready;
    assign r_fire    = rvalid_q & i_rready;
    assign aw_fire   = i_awvalid & o_awready;
    assign w_fire    = i_wvalid & o_wready;
    assign b_fire    = bvalid_q & i_bready;

    assign o_rid    = rid_q;
    assign o_rdata  = rdata_q;
    assign o_rresp  = rresp_q;
    assign o_rlast  = rlast_q;
    assign o_rvalid = rvalid_q;
    assign o_bid    = wid_q;
    assign o_bresp  = bresp_q;
    assign o_bvalid = bvalid_q;

    // Select the burst descriptor and address of the beat that will be loaded into the R register.
    always_comb begin
        ld_addr  = raddr_q;
        ld_len   = rlen_q;
        ld_size  = rsize_q;
        ld_burst = rburst_q;
        ld_last  = (rlen_q == 8'd0);
        case (r_state_q)
            R_IDLE: begin
                ld_addr  = i_araddr;
                ld_len   = i_arlen;
                ld_size  = i_arsize;
                ld_burst = i_arburst;
                ld_last  = (i_arlen == 8'd0);
            end
            R_DATA: begin
                ld_addr = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
                ld_last = ((rcnt_q + 8'd1) == rlen_q);
            end
            default: ;
        endcase
    end

    // Read FSM. The beat is fetched from the array as it is registered, so R outputs hold while stalled.
    always_comb begin
        r_state_d = r_state_q;
        lat_d     = lat_q;
        rid_d     = rid_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rcnt_d    = rcnt_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        r_load    = 1'b0;
        rd_err    = beat_err(ld_addr, ld_len, ld_size, ld_burst);
        case (r_state_q)
            R_IDLE: if (ar_fire) begin
                rid_d    = i_arid;
                raddr_d  = i_araddr;
                rlen_d   = i_arlen;
                rsize_d  = i_arsize;
                rburst_d = i_arburst;
                rcnt_d   = 8'd0;
                lat_d    = 3'd0;
                if (READ_LATENCY <= 1) begin
                    r_state_d = R_DATA;
                    r_load    = 1'b1;
                end else begin
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: if (lat_q == LAT_LAST) begin
                r_state_d = R_DATA;
                r_load    = 1'b1;
            end else begin
                lat_d = lat_q + 3'd1;
            end
            R_DATA: if (r_fire) begin
                if (rlast_q) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                    rlast_d   = 1'b0;
                end else begin
                    raddr_d = ld_addr;
                    rcnt_d  = rcnt_q + 8'd1;
                    r_load  = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (r_load) begin
            rvalid_d = 1'b1;
            rlast_d  = ld_last;
            rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
            rdata_d  = rd_err ? '0 : mem[word_idx(ld_addr)];
        end
    end

    // Read channel registers.
    always_ff @(posedge i_aclk or negedge i_arsetn) begin
        if (!i_arsetn) begin
            r_state_q <= R_IDLE;
            lat_q     <= 3'd0;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= 8'd0;
            rsize_q   <= 3'd0;
            rburst_q  <= 2'd0;
            rcnt_q    <= 8'd0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            lat_q     <= lat_d;
            rid_q     <= rid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rcnt_q    <= rcnt_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    // Write FSM. The burst always ends at beat awlen; a misplaced WLAST only poisons the response.
    always_comb begin
        w_state_d    = w_state_q;
        wid_d        = wid_q;
        waddr_d      = waddr_q;
        wlen_d       = wlen_q;
        wsize_d      = wsize_q;
        wburst_d     = wburst_q;
        wcnt_d       = wcnt_q;
        werr_d       = werr_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        wr_err       = beat_err(waddr_q, wlen_q, wsize_q, wburst_q);
        wr_last_beat = (wcnt_q == wlen_q);
        mem_we       = w_fire && !wr_err;
        case (w_state_q)
            W_IDLE: if (aw_fire) begin
                wid_d     = i_awid;
                waddr_d   = i_awaddr;
                wlen_d    = i_awlen;
                wsize_d   = i_awsize;
                wburst_d  = i_awburst;
                wcnt_d    = 8'd0;
                werr_d    = 1'b0;
                w_state_d = W_DATA;
            end
            W_DATA: if (w_fire) begin
                werr_d = werr_q | wr_err | (i_wlast != wr_last_beat);
                if (wr_last_beat) begin
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                    bresp_d   = werr_d ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
                    wcnt_d  = wcnt_q + 8'd1;
                end
            end
            W_RESP: if (b_fire) begin
                w_state_d = W_IDLE;
                bvalid_d  = 1'b0;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write channel registers.
    always_ff @(posedge i_aclk or negedge i_arsetn) begin
        if (!i_arsetn) begin
            w_state_q <= W_IDLE;
            wid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= 8'd0;
            wsize_q   <= 3'd0;
            wburst_q  <= 2'd0;
            wcnt_q    <= 8'd0;
            werr_q    <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            wid_q     <= wid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Byte-lane array update; contents survive reset.
    always_ff @(posedge i_aclk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (i_wstrb[b]) mem[word_idx(waddr_q)][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050710_axi4full_sram_burst.sv
// Directed bench for ysyx_22050710_axi4full_sram_burst. Instance 0 uses read latency 1
// and instance 1 uses read latency 3. Read bursts are checked against a vector table.
module tb_ysyx_22050710_axi4full_sram_burst;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  awid [2];
    logic [31:0] awaddr [2];
    logic [7:0]  awlen [2];
    logic [2:0]  awsize [2];
    logic [1:0]  awburst [2];
    logic        awvalid [2];
    logic        awready [2];
    logic [63:0] wdata [2];
    logic [7:0]  wstrb [2];
    logic        wlast [2];
    logic        wvalid [2];
    logic        wready [2];
    logic [3:0]  bid [2];
    logic [1:0]  bresp [2];
    logic        bvalid [2];
    logic        bready [2];
    logic [3:0]  arid [2];
    logic [31:0] araddr [2];
    logic [7:0]  arlen [2];
    logic [2:0]  arsize [2];
    logic [1:0]  arburst [2];
    logic        arvalid [2];
    logic        arready [2];
    logic [3:0]  rid [2];
    logic [63:0] rdata [2];
    logic [1:0]  rresp [2];
    logic        rlast [2];
    logic        rvalid [2];
    logic        rready [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ysyx_22050710_axi4full_sram_burst #(.READ_LATENCY(g == 0 ? 1 : 3)) u_dut (
            .i_aclk(clk), .i_arsetn(rst_n),
            .i_awid(awid[g]), .i_awaddr(awaddr[g]), .i_awlen(awlen[g]), .i_awsize(awsize[g]),
            .i_awburst(awburst[g]), .i_awvalid(awvalid[g]), .o_awready(awready[g]),
            .i_wdata(wdata[g]), .i_wstrb(wstrb[g]), .i_wlast(wlast[g]), .i_wvalid(wvalid[g]),
            .o_wready(wready[g]),
            .o_bid(bid[g]), .o_bresp(bresp[g]), .o_bvalid(bvalid[g]), .i_bready(bready[g]),
            .i_arid(arid[g]), .i_araddr(araddr[g]), .i_arlen(arlen[g]), .i_arsize(arsize[g]),
            .i_arburst(arburst[g]), .i_arvalid(arvalid[g]), .o_arready(arready[g]),
            .o_rid(rid[g]), .o_rdata(rdata[g]), .o_rresp(rresp[g]), .o_rlast(rlast[g]),
            .o_rvalid(rvalid[g]), .i_rready(rready[g])
        );
    end

    typedef struct packed {
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [3:0]       id;
        logic             stall;
        logic [1:0]       resp;
        logic [3:0][63:0] data;
    } rd_vec_t;

    localparam int NV = 12;
    rd_vec_t vecs [NV];
    int exp_lat [2];
    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] q_data [$];
    logic [1:0]  q_resp [$];
    logic        q_last [$];
    logic [3:0]  q_id [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic axi_write(input int d, input logic [3:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                             input logic [63:0] base, input logic [7:0] strb, input int last_at,
                             output logic [1:0] resp, output logic [3:0] rbid);
        int g;
        @(negedge clk);
        awid[d] = id; awaddr[d] = addr; awlen[d] = len; awsize[d] = size; awburst[d] = burst;
        awvalid[d] = 1'b1;
        g = 0;
        while (!awready[d] && g < 50) begin @(negedge clk); g++; end
        chk("aw_handshake", 64'(g < 50), 64'd1);
        @(negedge clk);
        awvalid[d] = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            wvalid[d] = 1'b1;
            wdata[d]  = base * 64'(k + 1);
            wstrb[d]  = strb;
            wlast[d]  = (k == last_at);
            g = 0;
            while (!wready[d] && g < 50) begin @(negedge clk); g++; end
            chk($sformatf("w_beat%0d_accepted", k), 64'(g < 50), 64'd1);
            @(negedge clk);
        end
        wvalid[d] = 1'b0;
        wlast[d]  = 1'b0;
        chk("bvalid_after_last_w", 64'(bvalid[d]), 64'd1);
        chk("wready_low_in_resp", 64'(wready[d]), 64'd0);
        @(negedge clk);
        chk("bvalid_held", 64'(bvalid[d]), 64'd1);
        resp = bresp[d];
        rbid = bid[d];
        bready[d] = 1'b1;
        @(negedge clk);
        bready[d] = 1'b0;
        chk("bvalid_low_after_b", 64'(bvalid[d]), 64'd0);
        chk("awready_after_b", 64'(awready[d]), 64'd1);
    endtask

    task automatic axi_read(input int d, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id,
                            input logic stall);
        int g;
        bit done, have_prev, prev_rdy, rdy;
        logic [63:0] pd;
        logic [1:0]  pr;
        logic        pl;
        q_data.delete(); q_resp.delete(); q_last.delete(); q_id.delete();
        @(negedge clk);
        chk("arready_idle", 64'(arready[d]), 64'd1);
        arid[d] = id; araddr[d] = addr; arlen[d] = len; arsize[d] = size; arburst[d] = burst;
        arvalid[d] = 1'b1;
        g = 0;
        do begin
            @(negedge clk);
            g++;
            if (g == 1) arvalid[d] = 1'b0;
        end while (!rvalid[d] && g < 40);
        chk($sformatf("rd_latency_dut%0d", d), 64'(g), 64'(exp_lat[d]));
        g = 0; done = 0; have_prev = 0; prev_rdy = 1; pd = '0; pr = '0; pl = 1'b0;
        while (!done && g < 200) begin
            if (rvalid[d]) begin
                if (have_prev && !prev_rdy) begin
                    chk("r_hold_data", rdata[d], pd);
                    chk("r_hold_last", 64'(rlast[d]), 64'(pl));
                    chk("r_hold_resp", 64'(rresp[d]), 64'(pr));
                end
                rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                rready[d] = rdy;
                pd = rdata[d]; pl = rlast[d]; pr = rresp[d]; prev_rdy = rdy; have_prev = 1;
                if (rdy) begin
                    q_data.push_back(rdata[d]); q_resp.push_back(rresp[d]);
                    q_last.push_back(rlast[d]); q_id.push_back(rid[d]);
                    done = rlast[d];
                end
            end else begin
                rready[d] = 1'b0;
                have_prev = 0;
            end
            @(negedge clk);
            g++;
        end
        rready[d] = 1'b0;
        chk("r_burst_completed", 64'(done), 64'd1);
        chk("rvalid_after_last", 64'(rvalid[d]), 64'd0);
        chk("arready_after_last", 64'(arready[d]), 64'd1);
    endtask

    task automatic check_beats(input string tag, input logic [7:0] len, input logic [3:0] id,
                               input logic [1:0] resp, input logic [3:0][63:0] data);
        chk({tag, "_nbeats"}, 64'(q_data.size()), 64'(len) + 64'd1);
        for (int k = 0; k < q_data.size() && k < 4; k++) begin
            chk($sformatf("%s_data%0d", tag, k), q_data[k], data[k]);
            chk($sformatf("%s_resp%0d", tag, k), 64'(q_resp[k]), 64'(resp));
            chk($sformatf("%s_last%0d", tag, k), 64'(q_last[k]), 64'(k == int'(len)));
            chk($sformatf("%s_id%0d", tag, k), 64'(q_id[k]), 64'(id));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] wr_resp;
        logic [3:0] wr_bid;

        exp_lat[0] = 1;
        exp_lat[1] = 3;
        //          addr          len   sz    burst  id    stall resp   data[3..0]
        vecs[0]  = '{32'h8000_0000, 8'd3, 3'd3, 2'b01, 4'h1, 1'b1, 2'b00, {64'h44, 64'h33, 64'h22, 64'h11}};
        vecs[1]  = '{32'h8000_0010, 8'd3, 3'd3, 2'b10, 4'h2, 1'b0, 2'b00, {64'h22, 64'h11, 64'h44, 64'h33}};
        vecs[2]  = '{32'h8000_0010, 8'd2, 3'd3, 2'b10, 4'h3, 1'b0, 2'b10, {64'h0, 64'h0, 64'h0, 64'h0}};
        vecs[3]  = '{32'h8000_0100, 8'd0, 3'd3, 2'b01, 4'h4, 1'b0, 2'b00, {64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_BBBB_BBBB}};
        vecs[4]  = '{32'h8000_0200, 8'd0, 3'd3, 2'b01, 4'h5, 1'b0, 2'b00, {64'h0, 64'h0, 64'h0, 64'h4}};
        vecs[5]  = '{32'h8000_0300, 8'd3, 3'd3, 2'b01, 4'h6, 1'b1, 2'b00, {64'h14, 64'h0F, 64'h0A, 64'h05}};
        vecs[6]  = '{32'h8000_8000, 8'd0, 3'd3, 2'b01, 4'h7, 1'b0, 2'b10, {64'h0, 64'h0, 64'h0, 64'h0}};
        vecs[7]  = '{32'h7FFF_FFF8, 8'd0, 3'd3, 2'b01, 4'h8, 1'b0, 2'b10, {64'h0, 64'h0, 64'h0, 64'h0}};
        vecs[8]  = '{32'h8000_0000, 8'd0, 3'd4, 2'b01, 4'h9, 1'b0, 2'b10, {64'h0, 64'h0, 64'h0, 64'h0}};
        vecs[9]  = '{32'h8000_0008, 8'd2, 3'd3, 2'b00, 4'hA, 1'b0, 2'b00, {64'h0, 64'h22, 64'h22, 64'h22}};
        vecs[10] = '{32'h8000_0000, 8'd1, 3'd2, 2'b01, 4'hB, 1'b0, 2'b00, {64'h0, 64'h0, 64'h11, 64'h11}};
        vecs[11] = '{32'h8000_0008, 8'd1, 3'd3, 2'b10, 4'hF, 1'b0, 2'b00, {64'h0, 64'h0, 64'h11, 64'h22}};

        for (int i = 0; i < 2; i++) begin
            awid[i] = '0; awaddr[i] = '0; awlen[i] = '0; awsize[i] = '0; awburst[i] = '0; awvalid[i] = 1'b0;
            wdata[i] = '0; wstrb[i] = '0; wlast[i] = 1'b0; wvalid[i] = 1'b0; bready[i] = 1'b0;
            arid[i] = '0; araddr[i] = '0; arlen[i] = '0; arsize[i] = '0; arburst[i] = '0; arvalid[i] = 1'b0;
            rready[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state of both instances.
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_arready%0d", i), 64'(arready[i]), 64'd1);
            chk($sformatf("rst_awready%0d", i), 64'(awready[i]), 64'd1);
            chk($sformatf("rst_wready%0d", i), 64'(wready[i]), 64'd0);
            chk($sformatf("rst_rvalid%0d", i), 64'(rvalid[i]), 64'd0);
            chk($sformatf("rst_rlast%0d", i), 64'(rlast[i]), 64'd0);
            chk($sformatf("rst_bvalid%0d", i), 64'(bvalid[i]), 64'd0);
            chk($sformatf("rst_rid%0d", i), 64'(rid[i]), 64'd0);
            chk($sformatf("rst_bid%0d", i), 64'(bid[i]), 64'd0);
            chk($sformatf("rst_rresp%0d", i), 64'(rresp[i]), 64'd0);
            chk($sformatf("rst_bresp%0d", i), 64'(bresp[i]), 64'd0);
            chk($sformatf("rst_rdata%0d", i), rdata[i], 64'd0);
        end

        // Write setup on instance 0.
        axi_write(0, 4'h3, 32'h8000_0000, 8'd3, 3'd3, 2'b01, 64'h11, 8'hFF, 3, wr_resp, wr_bid);
        chk("w_incr_bresp", 64'(wr_resp), 64'd0);
        chk("w_incr_bid", 64'(wr_bid), 64'h3);
        axi_write(0, 4'h1, 32'h8000_0100, 8'd0, 3'd3, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, wr_resp, wr_bid);
        chk("w_ones_bresp", 64'(wr_resp), 64'd0);
        axi_write(0, 4'h2, 32'h8000_0100, 8'd0, 3'd3, 2'b01, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 0, wr_resp, wr_bid);
        chk("w_strb_bresp", 64'(wr_resp), 64'd0);
        axi_write(0, 4'h4, 32'h8000_0100, 8'd0, 3'd4, 2'b01, 64'h0, 8'hFF, 0, wr_resp, wr_bid);
        chk("w_badsize_bresp", 64'(wr_resp), 64'd2);
        axi_write(0, 4'h5, 32'h8000_0200, 8'd3, 3'd3, 2'b00, 64'h1, 8'hFF, 3, wr_resp, wr_bid);
        chk("w_fixed_bresp", 64'(wr_resp), 64'd0);
        axi_write(0, 4'h6, 32'h8000_0300, 8'd3, 3'd3, 2'b01, 64'h5, 8'hFF, 2, wr_resp, wr_bid);
        chk("w_wlast_early_bresp", 64'(wr_resp), 64'd2);
        chk("w_wlast_early_bid", 64'(wr_bid), 64'h6);
        axi_write(0, 4'h7, 32'h8000_8000, 8'd0, 3'd3, 2'b01, 64'h77, 8'hFF, 0, wr_resp, wr_bid);
        chk("w_oob_bresp", 64'(wr_resp), 64'd2);

        // Table-driven read bursts on instance 0.
        for (int i = 0; i < NV; i++) begin
            axi_read(0, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, vecs[i].id, vecs[i].stall);
            check_beats($sformatf("v%0d", i), vecs[i].len, vecs[i].id, vecs[i].resp, vecs[i].data);
        end

        // Read latency 3 with random stalls on instance 1.
        axi_write(1, 4'h9, 32'h8000_0000, 8'd3, 3'd3, 2'b01, 64'h11, 8'hFF, 3, wr_resp, wr_bid);
        chk("l3_bresp", 64'(wr_resp), 64'd0);
        chk("l3_bid", 64'(wr_bid), 64'h9);
        axi_read(1, 32'h8000_0000, 8'd3, 3'd3, 2'b01, 4'hC, 1'b1);
        check_beats("l3_read", 8'd3, 4'hC, 2'b00, {64'h44, 64'h33, 64'h22, 64'h11});

        // Concurrent write and read bursts on instance 0.
        fork
            begin
                logic [1:0] cr;
                logic [3:0] cb;
                axi_write(0, 4'hD, 32'h8000_0400, 8'd3, 3'd3, 2'b01, 64'h21, 8'hFF, 3, cr, cb);
                chk("conc_bresp", 64'(cr), 64'd0);
                chk("conc_bid", 64'(cb), 64'hD);
            end
            axi_read(0, 32'h8000_0000, 8'd3, 3'd3, 2'b01, 4'hE, 1'b1);
        join
        check_beats("conc_read", 8'd3, 4'hE, 2'b00, {64'h44, 64'h33, 64'h22, 64'h11});
        axi_read(0, 32'h8000_0400, 8'd3, 3'd3, 2'b01, 4'h1, 1'b0);
        check_beats("conc_after", 8'd3, 4'h1, 2'b00, {64'h84, 64'h63, 64'h42, 64'h21});

        // Reset pulse in the middle of a read burst.
        @(negedge clk);
        araddr[0] = 32'h8000_0000; arlen[0] = 8'd3; arsize[0] = 3'd3; arburst[0] = 2'b01;
        arid[0] = 4'h6; arvalid[0] = 1'b1;
        @(negedge clk);
        arvalid[0] = 1'b0;
        chk("mid_rvalid_first", 64'(rvalid[0]), 64'd1);
        rready[0] = 1'b1;
        @(negedge clk);
        rready[0] = 1'b0;
        chk("mid_second_beat", rdata[0], 64'h22);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", 64'(rvalid[0]), 64'd0);
        chk("mid_rst_rlast", 64'(rlast[0]), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_arready", 64'(arready[0]), 64'd1);
        chk("post_rst_rvalid", 64'(rvalid[0]), 64'd0);
        axi_read(0, 32'h8000_0000, 8'd3, 3'd3, 2'b01, 4'h2, 1'b0);
        check_beats("post_rst_read", 8'd3, 4'h2, 2'b00, {64'h44, 64'h33, 64'h22, 64'h11});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22050710_axi4full_sram_burst.md
# ysyx_22050710_axi4full_sram_burst

AXI4-full slave wrapping an internal, parametrised SRAM array with full burst support (FIXED/INCR/WRAP), byte-lane narrow transfers, configurable read latency and error responses. It replaces the single-beat DPI-backed memory wrap behind the NPC crossbar for cache refills and write-backs. Read and write channels run independently and concurrently.

## Interface
- DATA_WIDTH, 64, data bus width; power of two, 32 or 64.
- ADDR_WIDTH, 32, address width.
- ID_WIDTH, 4, AXI ID width.
- MEM_WORDS, 4096, array depth in DATA_WIDTH words; power of two.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- READ_LATENCY, 1, cycles from AR handshake to first o_rvalid; legal 1..4.
- STRB_WIDTH, DATA_WIDTH/8, derived.

- i_aclk  in  1  clock.
- i_arsetn  in  1  reset; asynchronous, active-low.
- i_awid / i_awaddr / i_awlen / i_awsize / i_awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address.
- i_awvalid in 1, o_awready out 1.
- i_wdata / i_wstrb / i_wlast / i_wvalid  in  DATA_WIDTH/STRB_WIDTH/1/1; o_wready out 1.
- o_bid / o_bresp / o_bvalid  out  ID_WIDTH/2/1; i_bready in 1.
- i_arid / i_araddr / i_arlen / i_arsize / i_arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  read address.
- i_arvalid in 1, o_arready out 1.
- o_rid / o_rdata / o_rresp / o_rlast / o_rvalid  out  ID_WIDTH/DATA_WIDTH/2/1/1; i_rready in 1.

## Operation
- Read FSM: R_IDLE (o_arready=1) -ar_fire-> R_WAIT (latency counter, skipped when READ_LATENCY=1) -> R_DATA -> R_IDLE on r_fire with o_rlast.
- Write FSM: W_IDLE (o_awready=1) -aw_fire-> W_DATA (o_wready=1) -> W_RESP after beat awlen accepted -> W_IDLE on b_fire. W beats before AW are not accepted.
- AW/AR fields (id, addr, len, size, burst) latched on handshake; o_rid/o_bid return latched id.
- Beat address: FIXED constant; INCR += 2^size; WRAP += 2^size, wrapped within the (len+1)*2^size aligned window. Burst code 2'b11 treated as INCR.
- Word index = (addr - BASE_ADDR) >> log2(STRB_WIDTH), MEM_WORDS bits, no wrap past array.
- Writes: on each w_fire, byte lanes with i_wstrb=1 written into the indexed word; lanes are not re-aligned (master places narrow data on its lanes).
- Error (resp 2'b10 SLVERR), evaluated per beat: address outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*STRB_WIDTH); size > log2(STRB_WIDTH); WRAP with len not in {1,3,7,15}. Errored read beat: o_rdata=0, o_rresp=2'b10. Errored write beat: no array update; sticky flag gives o_bresp=2'b10.
- i_wlast mismatch (high before beat awlen, or low on beat awlen): burst still ends at beat awlen; o_bresp=2'b10.
- Same-word read and write in one cycle: read returns old data.
- Array contents are not reset.

## Timing
- Reset values: o_arready=1, o_awready=1, o_wready=0, o_rvalid=0, o_rlast=0, o_bvalid=0, o_rid=0, o_bid=0, o_rresp=0, o_bresp=0, o_rdata=0.
- Reset asserted mid-burst aborts immediately; no R or B for the aborted transaction.
- First o_rvalid exactly READ_LATENCY cycles after ar_fire; then one beat per cycle while i_rready=1.
- o_rvalid/o_rdata/o_rresp/o_rlast stable while o_rvalid=1 and i_rready=0.
- o_rlast high only on beat arlen; o_arready returns 1 the cycle after the last r_fire.
- o_wready high every W_DATA cycle: one beat per cycle.
- o_bvalid rises the cycle after the last w_fire; held until i_bready; o_awready returns 1 the cycle after b_fire.

## Test plan
- Write INCR len=3 size=3 at 0x8000_0000, data 0x11..0x44, wstrb=0xFF; read back INCR len=3 -> four beats 0x11,0x22,0x33,0x44, rlast on beat 4 only, rresp=0, bresp=0, ids echoed.
- WRAP len=3 size=3 read at 0x8000_0010 -> addresses 0x10,0x18,0x00,0x08; WRAP len=2 -> all beats rresp=2'b10, rdata=0.
- Write wstrb=0x0F data 0xAAAA_AAAA_BBBB_BBBB over word 0xFFFF_FFFF_FFFF_FFFF -> reads 0xFFFF_FFFF_BBBB_BBBB; FIXED len=3 write -> only last beat's data remains.
- READ_LATENCY=3: ar_fire at cycle T -> rvalid first at T+3; random rready stalls -> data held, no beat lost or duplicated.
- Read at BASE_ADDR + MEM_WORDS*8 -> rresp=2'b10, rdata=0; write with wlast on beat 2 of len=3 -> bresp=2'b10, beats 0..3 still accepted.
- Concurrent read and write bursts; reset pulse mid-read-burst -> rvalid low at once, o_arready=1 after release, next read returns correct data.
